number_to_digits: RTL and testbench
===================================

NUMBER_TO_DIGITS -- requirements
Module: number_to_digits

Interface
REQ-001 Parameter WIDTH, default 16, is the input word width; legal range 4..32.
REQ-002 Parameter DIGITS, default 5, is the maximum decimal digit count; legal only when 10^DIGITS > 2^WIDTH.
REQ-003 Parameter SIGNED, default 0; 1 means din is two's complement and negative values get a sign code.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 din  input  WIDTH  value to convert; sampled only on the accepting edge.
REQ-007 wen  input  1  load strobe; accepted only when busy=0.
REQ-008 busy  output  1  conversion or emission in progress.
REQ-009 dout  output  4  output code: 0..9 decimal digit, 4'hA minus sign.
REQ-010 dvalid  output  1  dout holds a valid code.
REQ-011 dready  input  1  consumer accepts dout; a transfer occurs on an edge where dvalid=1 and dready=1.
REQ-012 dlast  output  1  high with the final code of a number; qualified by dvalid.

Function
REQ-013 States SHALL be IDLE, CONVERT, SIGN, EMIT.
REQ-014 IDLE with wen=1 at edge T: latch magnitude, go to CONVERT, busy=1 from T+1.
REQ-015 wen while busy=1 SHALL be ignored; the number in flight is unaffected.
REQ-016 Magnitude: din when SIGNED=0 or din MSB=0; otherwise the WIDTH-bit unsigned two's-complement negation (-2^(WIDTH-1) yields 2^(WIDTH-1)).
REQ-017 CONVERT runs double-dabble: per cycle, add 3 to each BCD nibble >=5, then shift one magnitude bit in; exactly WIDTH cycles.
REQ-018 After the last CONVERT cycle: go to SIGN if the value is negative, else EMIT; dvalid=1 from edge T+WIDTH+1.
REQ-019 SIGN presents dout=4'hA, dlast=0; on transfer, go to EMIT.
REQ-020 EMIT begins at the most significant nonzero BCD digit, from a combinational priority encode with no bubble cycle; magnitude 0 emits a single 0.
REQ-021 EMIT presents one digit per transfer, most significant first; dlast=1 on the units digit.
REQ-022 With dready held high, one code SHALL transfer per cycle with no gaps.
REQ-023 With dvalid=1 and dready=0, dout, dlast and dvalid SHALL hold stable.
REQ-024 On the dlast transfer edge: go to IDLE; dvalid=0 and busy=0 after that edge.
REQ-025 A wen on the cycle after the dlast transfer SHALL be accepted normally.
REQ-026 dout and dlast SHALL be 0 whenever dvalid=0.

Reset
REQ-027 rst=1 SHALL immediately force IDLE and set busy=0, dvalid=0, dlast=0, dout=0, and BCD/shift/counter registers to 0, independent of clk.
REQ-028 Reset mid-operation discards the number in flight; no further codes of it appear.
REQ-029 The first wen accepted after rst deasserts converts normally.

Structure
REQ-030 Package number_to_digits_pkg SHALL hold the state encoding, SIGN_CODE=4'hA, and the BCD nibble width constant.
REQ-031 Per-cycle add-3-and-shift logic SHALL be one combinational sub-module, double_dabble_step, parametrised by DIGITS.
REQ-032 The shift counter SHALL be ceil(log2(WIDTH+1)) bits wide; the BCD register is 4*DIGITS bits.

Verification
REQ-033 WIDTH=16, SIGNED=0, din=123, wen one cycle, dready=1 -> codes 1,2,3, dlast on 3, first dvalid 17 edges after the wen edge.
REQ-034 din=65535 -> 6,5,5,3,5 on consecutive cycles, dlast on the final 5; busy=0 the cycle after.
REQ-035 din=0 -> single code 0 with dlast=1; din=1000 -> 1,0,0,0 (embedded zeros kept).
REQ-036 SIGNED=1: din=16'h8000 -> A,3,2,7,6,8; din=16'hFFFB -> A,5; din=16'h0007 -> 7 with no sign.
REQ-037 din=65535, dready low for 3 cycles after the second transfer -> dout=5 held stable, no loss or duplication; wen with din=9 during busy is ignored.
REQ-038 rst pulse during EMIT of 65535 -> dvalid/busy drop without a clock edge; a following wen with din=42 yields 4,2.

Source files
------------

// File: rtl/number_to_digits_pkg.sv
`default_nettype none
// ============================================================================
// Module      : number_to_digits_pkg
// Description : Shared definitions for the binary-to-decimal digit streamer.
//               Holds the controller state encoding, the code used for a
//               leading minus sign, and the width of one BCD nibble.
// Revision    : 1.0 - initial release
// ============================================================================
package number_to_digits_pkg;

  // Width of one BCD digit
  localparam int NIBBLE_W = 4;

  // Code presented on dout ahead of the digits of a negative number
  localparam logic [3:0] SIGN_CODE = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SIGN    = 2'd2,
    ST_EMIT    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/double_dabble_step.sv
`default_nettype none
// ============================================================================
// Module      : double_dabble_step
// Description : One combinational iteration of the double-dabble algorithm.
//               Every nibble >= 5 is corrected by +3, then the whole BCD
//               vector shifts left by one with bit_in entering at the LSB.
// Ports       : bcd_in  - current BCD accumulator (DIGITS nibbles)
//               bit_in  - next magnitude bit, MSB first
//               bcd_out - accumulator after add-3 and shift
// Revision    : 1.0 - initial release
// ============================================================================
module double_dabble_step
  import number_to_digits_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [NIBBLE_W*DIGITS-1:0] bcd_in,
  input  logic                       bit_in,
  output logic [NIBBLE_W*DIGITS-1:0] bcd_out
);

  // For a legal BCD nibble (0..9) the corrected value has its MSB set
  // exactly when the nibble was >= 5, so the bit carried into the next
  // nibble is just that comparison.
  logic [DIGITS-1:0] w_ge5;

  for (genvar i = 0; i < DIGITS; i++) begin : g_nib
    logic [NIBBLE_W-1:0] w_nib;
    logic [NIBBLE_W-2:0] w_low;

    assign w_nib    = bcd_in[NIBBLE_W*i +: NIBBLE_W];
    assign w_ge5[i] = (w_nib >= 4'd5);
    assign w_low    = w_ge5[i] ? 3'(w_nib + 4'd3) : w_nib[NIBBLE_W-2:0];

    if (i == 0) begin : g_lsn
      assign bcd_out[NIBBLE_W*i +: NIBBLE_W] = {w_low, bit_in};
    end else begin : g_upper
      assign bcd_out[NIBBLE_W*i +: NIBBLE_W] = {w_low, w_ge5[i-1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/number_to_digits.sv
`default_nettype none
// ============================================================================
// Module      : number_to_digits
// Description : Converts a binary word to decimal and streams the digits out
//               most significant first over a valid/ready handshake, with an
//               optional leading minus code for two's-complement input.
// Ports       : clk    - clock, rising edge
//               rst    - asynchronous active-high reset
//               din    - value to convert, sampled when wen is accepted
//               wen    - load strobe, accepted only while busy=0
//               busy   - conversion or emission in progress
//               dout   - 0..9 digit or SIGN_CODE
//               dvalid - dout holds a valid code
//               dready - consumer accepts dout
//               dlast  - final code of the number (qualified by dvalid)
// Revision    : 1.0 - initial release
// ============================================================================
module number_to_digits
  import number_to_digits_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic             busy,
  output logic [3:0]       dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             dlast
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam int c_idx_w = $clog2(DIGITS);
  localparam int c_bcd_w = NIBBLE_W * DIGITS;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_bcd_w-1:0]   r_bcd;
  logic [c_bcd_w-1:0]   w_bcd_step;
  logic [WIDTH-1:0]     r_shift;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_neg;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_idx_w-1:0]   w_msd;
  logic [WIDTH-1:0]     w_mag;
  logic                 w_neg_in;
  logic [3:0]           w_nib [DIGITS];
  logic                 w_units;
  logic                 w_done;

  // Unsigned negation also maps the most negative input onto 2^(WIDTH-1)
  assign w_neg_in = SIGNED && din[WIDTH-1];
  assign w_mag    = w_neg_in ? (~din + WIDTH'(1)) : din;

  // The extra CONVERT cycle at r_cnt==WIDTH lets the final BCD value settle
  // in r_bcd before the digit index is loaded from it.
  assign w_done   = (r_cnt == c_cnt_last);
  assign w_units  = (r_idx == '0);

  double_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .bcd_in  (r_bcd),
    .bit_in  (r_shift[WIDTH-1]),
    .bcd_out (w_bcd_step)
  );

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign w_nib[i] = r_bcd[NIBBLE_W*i +: NIBBLE_W];
  end

  // Highest nonzero digit; falls back to the units digit so zero emits "0"
  always_comb begin
    w_msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (w_nib[i] != 4'd0) w_msd = c_idx_w'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    dvalid      = 1'b0;
    dout        = 4'd0;
    dlast       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (wen) w_state_nxt = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (w_done) w_state_nxt = r_neg ? ST_SIGN : ST_EMIT;
      end
      ST_SIGN: begin
        dvalid = 1'b1;
        dout   = SIGN_CODE;
        if (dready) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        dvalid = 1'b1;
        dout   = w_nib[r_idx];
        dlast  = w_units;
        if (dready && w_units) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd   <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (wen) begin
            r_bcd   <= '0;
            r_shift <= w_mag;
            r_cnt   <= '0;
            r_neg   <= w_neg_in;
          end
        end
        ST_CONVERT: begin
          if (!w_done) begin
            r_bcd   <= w_bcd_step;
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + c_cnt_w'(1);
          end else if (!r_neg) begin
            r_idx   <= w_msd;
          end
        end
        ST_SIGN: begin
          if (dready) r_idx <= w_msd;
        end
        ST_EMIT: begin
          if (dready && !w_units) r_idx <= r_idx - c_idx_w'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_number_to_digits.sv
`default_nettype none
// ============================================================================
// Module      : tb_number_to_digits
// Description : Self-checking bench for number_to_digits. An unsigned and a
//               signed instance (WIDTH=16, DIGITS=5) are driven with table
//               vectors, handshake/reset corner sequences and random values
//               checked against a decimal-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_number_to_digits;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din    [2];
  logic        wen    [2];
  logic        dready [2];
  logic        busy   [2];
  logic [3:0]  dout   [2];
  logic        dvalid [2];
  logic        dlast  [2];

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    int          s;
    logic [15:0] v;
    int          n;
    int          c[6];
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  number_to_digits #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .din(din[0]), .wen(wen[0]), .busy(busy[0]),
    .dout(dout[0]), .dvalid(dvalid[0]), .dready(dready[0]), .dlast(dlast[0])
  );

  number_to_digits #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .din(din[1]), .wen(wen[1]), .busy(busy[1]),
    .dout(dout[1]), .dvalid(dvalid[1]), .dready(dready[1]), .dlast(dlast[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Expected code stream from plain decimal arithmetic
  task automatic model(input int s, input logic [15:0] v);
    int mag;
    int d[$];
    exp_q.delete();
    if (s == 1 && v[15]) begin
      exp_q.push_back(10);
      mag = 65536 - int'(v);
    end else begin
      mag = int'(v);
    end
    do begin
      d.push_front(mag % 10);
      mag = mag / 10;
    end while (mag > 0);
    foreach (d[i]) exp_q.push_back(d[i]);
  endtask

  // rmode 0: dready always 1 (latency/no-gap checked)
  // rmode 1: random dready
  // rmode 2: dready low for 3 cycles after the second transfer
  task automatic run_num(input int s, input logic [15:0] v, input int rmode,
                         input bit poke, input string tag);
    int k = 0;
    int xfers = 0;
    int lowcnt = 0;
    bit done = 1'b0;
    bit hold = 1'b0;
    logic [3:0] pd = 4'd0;
    logic pl = 1'b0;
    @(negedge clk);
    din[s] = v; wen[s] = 1'b1; dready[s] = 1'b1;
    @(posedge clk);
    #1 wen[s] = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (n == 0) chk({tag, " busy after load"}, busy[s], 1);
      if (hold) begin
        chk({tag, " stall dvalid"}, dvalid[s], 1);
        chk({tag, " stall dout"}, dout[s], pd);
        chk({tag, " stall dlast"}, dlast[s], pl);
      end
      if (!dvalid[s]) chk({tag, " idle dout/dlast"}, {dout[s], dlast[s]}, 0);
      if (poke && n == 3) begin
        wen[s] = 1'b1; din[s] = 16'd9;
      end else if (poke && n == 4) begin
        wen[s] = 1'b0;
      end
      case (rmode)
        0: dready[s] = 1'b1;
        1: dready[s] = 1'($urandom_range(0, 1));
        default: begin
          if (xfers == 2 && lowcnt < 3) begin
            dready[s] = 1'b0; lowcnt++;
          end else dready[s] = 1'b1;
        end
      endcase
      hold = dvalid[s] && !dready[s];
      pd   = dout[s];
      pl   = dlast[s];
      if (dvalid[s] && dready[s]) begin
        if (k < exp_q.size()) begin
          chk($sformatf("%s code%0d", tag, k), dout[s], exp_q[k]);
          chk($sformatf("%s dlast%0d", tag, k), dlast[s], (k == exp_q.size() - 1));
        end else begin
          chk({tag, " extra code"}, 1, 0);
        end
        if (rmode == 0) chk($sformatf("%s timing%0d", tag, k), n, 17 + k);
        k++; xfers++;
        if (dlast[s] || k >= exp_q.size()) done = 1'b1;
      end
    end
    if (!done) chk({tag, " timeout"}, 0, 1);
    dready[s] = 1'b1;
    @(negedge clk);
    chk({tag, " busy after last"}, busy[s], 0);
    chk({tag, " dvalid after last"}, dvalid[s], 0);
  endtask

  initial begin
    int n;
    int s;
    logic [15:0] v;

    vecs[0] = '{s: 0, v: 16'd123,   n: 3, c: '{1, 2, 3, 0, 0, 0}};
    vecs[1] = '{s: 0, v: 16'd65535, n: 5, c: '{6, 5, 5, 3, 5, 0}};
    vecs[2] = '{s: 0, v: 16'd0,     n: 1, c: '{0, 0, 0, 0, 0, 0}};
    vecs[3] = '{s: 0, v: 16'd1000,  n: 4, c: '{1, 0, 0, 0, 0, 0}};
    vecs[4] = '{s: 1, v: 16'h8000,  n: 6, c: '{10, 3, 2, 7, 6, 8}};
    vecs[5] = '{s: 1, v: 16'hFFFB,  n: 2, c: '{10, 5, 0, 0, 0, 0}};
    vecs[6] = '{s: 1, v: 16'h0007,  n: 1, c: '{7, 0, 0, 0, 0, 0}};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din[i] = 16'd0; wen[i] = 1'b0; dready[i] = 1'b1;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset busy%0d", i), busy[i], 0);
      chk($sformatf("reset dvalid%0d", i), dvalid[i], 0);
      chk($sformatf("reset dout%0d", i), dout[i], 0);
      chk($sformatf("reset dlast%0d", i), dlast[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      exp_q.delete();
      for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].c[j]);
      run_num(vecs[i].s, vecs[i].v, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Back-pressure hold plus an ignored wen during busy
    exp_q = '{6, 5, 5, 3, 5};
    run_num(0, 16'hFFFF, 2, 1'b1, "hold");

    // Asynchronous reset during emission
    @(negedge clk);
    din[0] = 16'hFFFF; wen[0] = 1'b1; dready[0] = 1'b1;
    @(posedge clk);
    #1 wen[0] = 1'b0;
    n = 0;
    while (!dvalid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst reached emit", dvalid[0], 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst async busy", busy[0], 0);
    chk("rst async dvalid", dvalid[0], 0);
    chk("rst async dout", dout[0], 0);
    chk("rst async dlast", dlast[0], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst no stale code", dvalid[0], 0);
    end
    exp_q = '{4, 2};
    run_num(0, 16'd42, 0, 1'b0, "after rst");

    // Random values against the reference model
    for (int i = 0; i < 40; i++) begin
      s = int'($urandom_range(0, 1));
      v = 16'($urandom);
      if (i % 8 == 1) v = 16'($urandom_range(0, 9));
      model(s, v);
      run_num(s, v, int'($urandom_range(0, 1)), (i % 5 == 0), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
